neokeon_decrypt_core: RTL and testbench



---
 rtl/neokeon_decrypt_core.sv | 185 ++++++++++++++++++
 tb/tb_neokeon_decrypt_core.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/neokeon_decrypt_core.sv
// Iterative NEOKEON-128 block decryptor, one round per clock, valid/ready on both sides.
// Optional key cache (skip KEYPREP on repeated key): define NEOKEON_DEC_KEYCACHE_EN.
module neokeon_decrypt_core #(
  parameter int          ROUNDS  = 16,
  parameter logic [7:0]  RC_LAST = 8'hD4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] inDataKey,
  input  logic [127:0] inDataState,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] outDataState,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    KEYPREP = 3'd1,
    ROUND   = 3'd2,
    FINAL   = 3'd3,
    HOLD    = 3'd4
  } state_t;

  state_t       r_state;
  state_t       w_nextState;
  logic [127:0] r_key;
  logic [127:0] r_keyPrime;
  logic [127:0] r_data;
  logic [127:0] r_outData;
  logic [7:0]   r_rc;
  logic [3:0]   r_count;
  logic         r_inReady;
  logic         r_outValid;

  logic         w_accept;
  logic         w_cacheHit;
  logic         w_lastRound;
  logic [7:0]   w_rcNext;
  logic [127:0] w_thetaOut;
  logic [127:0] w_roundOut;
  logic [127:0] w_finalOut;

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] theta(input logic [127:0] k, input logic [127:0] a);
    logic [31:0] a0, a1, a2, a3, t;
    a0 = a[127:96];
    a1 = a[95:64];
    a2 = a[63:32];
    a3 = a[31:0];
    t  = a0 ^ a2;
    t  = t ^ rotl(t, 8) ^ rotl(t, 24);
    a1 = a1 ^ t;
    a3 = a3 ^ t;
    a0 = a0 ^ k[127:96];
    a1 = a1 ^ k[95:64];
    a2 = a2 ^ k[63:32];
    a3 = a3 ^ k[31:0];
    t  = a1 ^ a3;
    t  = t ^ rotl(t, 8) ^ rotl(t, 24);
    a0 = a0 ^ t;
    a2 = a2 ^ t;
    return {a0, a1, a2, a3};
  endfunction

  function automatic logic [127:0] pi1(input logic [127:0] a);
    return {a[127:96], rotl(a[95:64], 1), rotl(a[63:32], 5), rotl(a[31:0], 2)};
  endfunction

  function automatic logic [127:0] pi2(input logic [127:0] a);
    return {a[127:96], rotl(a[95:64], 31), rotl(a[63:32], 27), rotl(a[31:0], 30)};
  endfunction

  // Gamma is its own inverse, so the encryption S-box network is reused unchanged.
  function automatic logic [127:0] gamma(input logic [127:0] a);
    logic [31:0] a0, a1, a2, a3, t;
    a0 = a[127:96];
    a1 = a[95:64];
    a2 = a[63:32];
    a3 = a[31:0];
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    t  = a3;
    a3 = a0;
    a0 = t;
    a2 = a2 ^ a0 ^ a1 ^ a3;
    a1 = a1 ^ (~a3 & ~a2);
    a0 = a0 ^ (a2 & a1);
    return {a0, a1, a2, a3};
  endfunction

  assign w_accept    = (r_state == IDLE) && in_valid && r_inReady;
  assign w_lastRound = (r_count == 4'(ROUNDS - 1));
  assign w_rcNext    = r_rc[0] ? (((r_rc ^ 8'h1B) >> 1) | 8'h80) : (r_rc >> 1);
  assign w_thetaOut  = theta(r_keyPrime, r_data);
  assign w_roundOut  = pi2(gamma(pi1(w_thetaOut ^ {24'h0, r_rc, 96'h0})));
  assign w_finalOut  = w_thetaOut ^ {24'h0, r_rc, 96'h0};

`ifdef NEOKEON_DEC_KEYCACHE_EN
  logic r_cacheValid;

  // r_key and r_keyPrime persist after a block, so a valid bit is all the cache needs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cacheValid <= 1'b0;
    end else if (r_state == KEYPREP) begin
      r_cacheValid <= 1'b1;
    end
  end

  assign w_cacheHit = r_cacheValid && (inDataKey == r_key);
`else
  assign w_cacheHit = 1'b0;
`endif

  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_nextState = w_cacheHit ? ROUND : KEYPREP;
      KEYPREP: w_nextState = ROUND;
      ROUND:   if (w_lastRound) w_nextState = FINAL;
      FINAL:   w_nextState = HOLD;
      HOLD:    if (r_outValid && out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_key      <= '0;
      r_keyPrime <= '0;
      r_data     <= '0;
      r_outData  <= '0;
      r_rc       <= '0;
      r_count    <= '0;
      r_inReady  <= 1'b0;
      r_outValid <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_inReady <= (w_nextState == IDLE);
      case (r_state)
        IDLE: begin
          // rc/count are preloaded here too so a cache hit can enter ROUND directly.
          if (w_accept) begin
            r_key   <= inDataKey;
            r_data  <= inDataState;
            r_rc    <= RC_LAST;
            r_count <= '0;
          end
        end
        KEYPREP: begin
          r_keyPrime <= theta(128'h0, r_key);
          r_rc       <= RC_LAST;
          r_count    <= '0;
        end
        ROUND: begin
          r_data  <= w_roundOut;
          r_rc    <= w_rcNext;
          r_count <= r_count + 4'd1;
        end
        FINAL: begin
          r_data     <= w_finalOut;
          r_outData  <= w_finalOut;
          r_outValid <= 1'b1;
        end
        HOLD: begin
          if (r_outValid && out_ready) r_outValid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready     = r_inReady;
  assign out_valid    = r_outValid;
  assign outDataState = r_outData;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_neokeon_decrypt_core.sv
// Self-checking bench for neokeon_decrypt_core: ciphertexts come from an encryption
// model here, and the core must return the original plaintext with the right timing.
module tb_neokeon_decrypt_core;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] inDataKey = '0;
  logic [127:0] inDataState = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] outDataState;
  logic         busy;

  int errors = 0;
  int checks = 0;

  logic [7:0]   rcTrace [0:40];
  logic [127:0] tbLastKey = '0;
  logic         tbLastValid = 1'b0;

  localparam int MISS_LAT = 18;
`ifdef NEOKEON_DEC_KEYCACHE_EN
  localparam int HIT_LAT = 17;
`else
  localparam int HIT_LAT = 18;
`endif

  always #5 clk = ~clk;

  neokeon_decrypt_core dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .inDataKey    (inDataKey),
    .inDataState  (inDataState),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .outDataState (outDataState),
    .busy         (busy)
  );

  // Encryption reference model, written word-array style from the published algorithm.
  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] mTheta(input logic [127:0] k, input logic [127:0] s);
    logic [31:0] w [4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = s[127 - 32*i -: 32];
    t = w[0] ^ w[2];
    t = t ^ rl(t, 8) ^ rl(t, 24);
    w[1] = w[1] ^ t;
    w[3] = w[3] ^ t;
    for (int i = 0; i < 4; i++) w[i] = w[i] ^ k[127 - 32*i -: 32];
    t = w[1] ^ w[3];
    t = t ^ rl(t, 8) ^ rl(t, 24);
    w[0] = w[0] ^ t;
    w[2] = w[2] ^ t;
    return {w[0], w[1], w[2], w[3]};
  endfunction

  function automatic logic [127:0] mRound(input logic [127:0] s);
    logic [31:0] w [4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = s[127 - 32*i -: 32];
    w[1] = rl(w[1], 1);
    w[2] = rl(w[2], 5);
    w[3] = rl(w[3], 2);
    w[1] = w[1] ^ (~w[3] & ~w[2]);
    w[0] = w[0] ^ (w[2] & w[1]);
    t    = w[3];
    w[3] = w[0];
    w[0] = t;
    w[2] = w[2] ^ w[0] ^ w[1] ^ w[3];
    w[1] = w[1] ^ (~w[3] & ~w[2]);
    w[0] = w[0] ^ (w[2] & w[1]);
    w[1] = rl(w[1], 31);
    w[2] = rl(w[2], 27);
    w[3] = rl(w[3], 30);
    return {w[0], w[1], w[2], w[3]};
  endfunction

  function automatic logic [127:0] encryptModel(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] s;
    logic [7:0]   rc;
    s  = pt;
    rc = 8'h80;
    for (int r = 0; r < 16; r++) begin
      s[127:96] = s[127:96] ^ {24'h0, rc};
      s  = mRound(mTheta(key, s));
      rc = rc[7] ? ((rc << 1) ^ 8'h1B) : (rc << 1);
    end
    s[127:96] = s[127:96] ^ {24'h0, rc};
    return mTheta(key, s);
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for in_ready, presents one block for one cycle, then scrambles the inputs.
  task automatic applyStimulus(input logic [127:0] key, input logic [127:0] ct);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("in_ready_before_accept", 128'(in_ready), 128'd1);
    in_valid    = 1'b1;
    inDataKey   = key;
    inDataState = ct;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    inDataKey   = ~key;
    inDataState = ~ct;
  endtask

  task automatic waitOutput(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      rcTrace[lat] = dut.r_rc;
    end
  endtask

  task automatic releaseOutput();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("out_valid_after_handshake", 128'(out_valid), 128'd0);
    checkOutput("busy_after_handshake", 128'(busy), 128'd0);
    checkOutput("in_ready_after_handshake", 128'(in_ready), 128'd1);
  endtask

  function automatic int expectedLatency(input logic [127:0] key);
    return (tbLastValid && key == tbLastKey) ? HIT_LAT : MISS_LAT;
  endfunction

  task automatic runBlock(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] ct;
    int lat, expLat;
    ct     = encryptModel(key, pt);
    expLat = expectedLatency(key);
    applyStimulus(key, ct);
    tbLastKey   = key;
    tbLastValid = 1'b1;
    waitOutput(lat);
    checkOutput("latency", 128'(lat), 128'(expLat));
    checkOutput("plaintext", outDataState, pt);
    releaseOutput();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]   expRc [17];
    logic [127:0] dKeys [4];
    logic [127:0] dPts  [4];
    logic [127:0] key, pt, ct;
    int lat;

    expRc = '{8'hD4, 8'h6A, 8'h35, 8'h97, 8'hC6, 8'h63, 8'hBC, 8'h5E, 8'h2F,
              8'h9A, 8'h4D, 8'hAB, 8'hD8, 8'h6C, 8'h36, 8'h1B, 8'h80};
    dKeys = '{128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF, 128'h0,
              128'h01234567_89ABCDEF_FEDCBA98_76543210, 128'h80000000_00000000_00000000_00000001};
    dPts  = '{128'h0, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF,
              128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 128'h00000000_00000000_00000000_00000001};

    // Reset values while rst is held, then in_ready one clock after release.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 128'(in_ready), 128'd0);
    checkOutput("reset_out_valid", 128'(out_valid), 128'd0);
    checkOutput("reset_busy", 128'(busy), 128'd0);
    checkOutput("reset_out_data", outDataState, 128'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("in_ready_after_reset", 128'(in_ready), 128'd1);

    // All-zero round trip with the round-constant trace.
    ct = encryptModel(128'h0, 128'h0);
    applyStimulus(128'h0, ct);
    tbLastKey   = 128'h0;
    tbLastValid = 1'b1;
    checkOutput("busy_after_accept", 128'(busy), 128'd1);
    waitOutput(lat);
    checkOutput("zero_latency", 128'(lat), 128'd18);
    checkOutput("zero_plaintext", outDataState, 128'h0);
    for (int i = 0; i < 17; i++) checkOutput("rc_trace", 128'(rcTrace[i + 1]), 128'(expRc[i]));
    releaseOutput();

    // Directed key/plaintext patterns.
    for (int i = 0; i < 4; i++) runBlock(dKeys[i], dPts[i]);

    // Same key twice (cache hit when enabled), then a different key.
    key = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
    runBlock(key, 128'h11111111_22222222_33333333_44444444);
    runBlock(key, 128'h55555555_66666666_77777777_88888888);
    runBlock(~key, 128'h99999999_AAAAAAAA_BBBBBBBB_CCCCCCCC);

    // Backpressure with in_valid pulses during HOLD.
    key = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
    pt  = 128'h13579BDF_02468ACE_FDB97531_ECA86420;
    applyStimulus(key, encryptModel(key, pt));
    waitOutput(lat);
    checkOutput("bp_latency", 128'(lat), 128'(expectedLatency(key)));
    tbLastKey   = key;
    tbLastValid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid    = c[0];
      inDataKey   = {4{$urandom}};
      inDataState = {4{$urandom}};
      @(posedge clk); #1;
      checkOutput("bp_data_stable", outDataState, pt);
      checkOutput("bp_out_valid", 128'(out_valid), 128'd1);
      checkOutput("bp_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    releaseOutput();

    // out_ready held high before out_valid: output still appears once, then drops.
    pt  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    key = 128'h000102030405060708090A0B0C0D0E0F;
    applyStimulus(key, encryptModel(key, pt));
    out_ready = 1'b1;
    waitOutput(lat);
    checkOutput("early_ready_latency", 128'(lat), 128'(expectedLatency(key)));
    checkOutput("early_ready_plaintext", outDataState, pt);
    tbLastKey   = key;
    tbLastValid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("early_ready_out_valid_drop", 128'(out_valid), 128'd0);

    // Reset in the middle of the rounds aborts the block.
    key = 128'hFEDCBA98_76543210_01234567_89ABCDEF;
    applyStimulus(key, encryptModel(key, 128'h1));
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_out_valid", 128'(out_valid), 128'd0);
    checkOutput("abort_busy", 128'(busy), 128'd0);
    checkOutput("abort_out_data", outDataState, 128'h0);
    checkOutput("abort_in_ready", 128'(in_ready), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    tbLastValid = 1'b0;
    @(posedge clk); #1;
    checkOutput("abort_in_ready_release", 128'(in_ready), 128'd1);
    runBlock(key, 128'h1);

    // Random key/plaintext pairs.
    for (int n = 0; n < 1000; n++) begin
      runBlock({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
